// File: rtl/video_timing_pkg.sv
// Raster timing constants for 1280x720@60. Shared by the signal generator,
// the half-resolution scaler and the frame-buffer logic.
package video_timing_pkg;
    localparam int ACTIVE_H_PIXELS = 1280;
    localparam int H_FRONT_PORCH   = 110;
    localparam int H_SYNC_WIDTH    = 40;
    localparam int H_BACK_PORCH    = 220;
    localparam int ACTIVE_LINES    = 720;
    localparam int V_FRONT_PORCH   = 5;
    localparam int V_SYNC_WIDTH    = 5;
    localparam int V_BACK_PORCH    = 20;
    localparam int FPS             = 60;

    localparam int H_TOTAL  = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL  = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;
    localparam int HS_START = ACTIVE_H_PIXELS + H_FRONT_PORCH;
    localparam int HS_END   = HS_START + H_SYNC_WIDTH;
    localparam int VS_START = ACTIVE_LINES + V_FRONT_PORCH;
    localparam int VS_END   = VS_START + V_SYNC_WIDTH;

    // Port widths are fixed; totals above 2047 / 1023 / 63 are not supported.
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int FC_W     = 6;
endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous reset. Exposes its next value so the
// parent can register decodes aligned with the count itself.
module wrap_counter #(
    parameter int MAX = 1,
    parameter int W   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         tc
);
    assign tc = (count == W'(MAX));

    always_comb begin
        count_next = count;
        if (rst)
            count_next = '0;
        else if (en)
            count_next = tc ? '0 : count + W'(1);
    end

    always_ff @(posedge clk)
        count <= count_next;
endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel position counters plus registered sync,
// active-draw, new-frame and frame-count outputs, all for the same position.
module video_sig_gen
    import video_timing_pkg::HCOUNT_W;
    import video_timing_pkg::VCOUNT_W;
    import video_timing_pkg::FC_W;
#(
    parameter int ACTIVE_H_PIXELS = video_timing_pkg::ACTIVE_H_PIXELS,
    parameter int H_FRONT_PORCH   = video_timing_pkg::H_FRONT_PORCH,
    parameter int H_SYNC_WIDTH    = video_timing_pkg::H_SYNC_WIDTH,
    parameter int H_BACK_PORCH    = video_timing_pkg::H_BACK_PORCH,
    parameter int ACTIVE_LINES    = video_timing_pkg::ACTIVE_LINES,
    parameter int V_FRONT_PORCH   = video_timing_pkg::V_FRONT_PORCH,
    parameter int V_SYNC_WIDTH    = video_timing_pkg::V_SYNC_WIDTH,
    parameter int V_BACK_PORCH    = video_timing_pkg::V_BACK_PORCH,
    parameter int FPS             = video_timing_pkg::FPS
) (
    input  logic                clk_pixel_in,
    input  logic                rst_in,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                hs_out,
    output logic                vs_out,
    output logic                ad_out,
    output logic                nf_out,
    output logic [FC_W-1:0]     fc_out
);
    localparam int H_TOTAL = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    localparam logic [HCOUNT_W-1:0] H_ACT = HCOUNT_W'(ACTIVE_H_PIXELS);
    localparam logic [HCOUNT_W-1:0] HS_S  = HCOUNT_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH);
    localparam logic [HCOUNT_W-1:0] HS_E  = HCOUNT_W'(ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH);
    localparam logic [VCOUNT_W-1:0] V_ACT = VCOUNT_W'(ACTIVE_LINES);
    localparam logic [VCOUNT_W-1:0] VS_S  = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH);
    localparam logic [VCOUNT_W-1:0] VS_E  = VCOUNT_W'(ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH);

    logic                started;
    logic [HCOUNT_W-1:0] h_next;
    logic [VCOUNT_W-1:0] v_next;
    logic [FC_W-1:0]     fc_next;
    logic                h_tc, v_tc, fc_tc;
    logic                nf_next;
    logic                unused_tc;

    // The first edge after release presents (0,0) without advancing.
    always_ff @(posedge clk_pixel_in)
        started <= !rst_in;

    wrap_counter #(.MAX(H_TOTAL - 1), .W(HCOUNT_W)) u_h (
        .clk(clk_pixel_in), .rst(rst_in), .en(started),
        .count(hcount_out), .count_next(h_next), .tc(h_tc)
    );

    wrap_counter #(.MAX(V_TOTAL - 1), .W(VCOUNT_W)) u_v (
        .clk(clk_pixel_in), .rst(rst_in), .en(started && h_tc),
        .count(vcount_out), .count_next(v_next), .tc(v_tc)
    );

    assign nf_next = (h_next == H_ACT) && (v_next == V_ACT);

    wrap_counter #(.MAX(FPS - 1), .W(FC_W)) u_fc (
        .clk(clk_pixel_in), .rst(rst_in), .en(nf_next),
        .count(fc_out), .count_next(fc_next), .tc(fc_tc)
    );

    assign unused_tc = v_tc | fc_tc | (|fc_next);

    // Decode the position the counters are about to hold so flags line up.
    always_ff @(posedge clk_pixel_in) begin
        if (rst_in) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            ad_out <= 1'b0;
            nf_out <= 1'b0;
        end else begin
            hs_out <= (h_next >= HS_S) && (h_next < HS_E);
            vs_out <= (v_next >= VS_S) && (v_next < VS_E);
            ad_out <= (h_next < H_ACT) && (v_next < V_ACT);
            nf_out <= nf_next;
        end
    end
endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Generates raster timing for the 1280x720@60 (CEA-861 720p) HDMI output.
- Produces the pixel position counters hcount_out/vcount_out, plus h/v sync, active-draw, new-frame and frame-count signals.
- Sits directly upstream of the half-resolution address scaler: its hcount_out/vcount_out feed that stage's hcount_in/vcount_in, and the sync/active outputs go on to the TMDS encoder pipeline.

Parameters:
- ACTIVE_H_PIXELS, 1280, visible pixels per line
- H_FRONT_PORCH, 110, pixels between end of active video and hsync
- H_SYNC_WIDTH, 40, hsync pulse width in pixels
- H_BACK_PORCH, 220, pixels after hsync before next line
- ACTIVE_LINES, 720, visible lines per frame
- V_FRONT_PORCH, 5, lines between end of active video and vsync
- V_SYNC_WIDTH, 5, vsync pulse width in lines
- V_BACK_PORCH, 20, lines after vsync before next frame
- FPS, 60, frame-counter modulus

Ports:
- clk_pixel_in, input, 1, 74.25 MHz pixel clock
- rst_in, input, 1, synchronous active-high reset
- hcount_out, output, 11, horizontal position, 0..H_TOTAL-1
- vcount_out, output, 10, vertical position, 0..V_TOTAL-1
- hs_out, output, 1, horizontal sync, active high
- vs_out, output, 1, vertical sync, active high
- ad_out, output, 1, active draw
- nf_out, output, 1, one-cycle new-frame pulse
- fc_out, output, 6, frame count, 0..FPS-1

Behaviour:
- Derived constants:
  - H_TOTAL = sum of horizontal parameters = 1650.
  - V_TOTAL = sum of vertical parameters = 750.
- Clocking and reset:
  - One clock domain.
  - Reset is synchronous and active-high on clk_pixel_in.
- Output timing: all outputs are registered, and all outputs in one cycle describe the same (h,v) position. No combinational path from input to output.
- Reset:
  - While rst_in = 1, every output = 0 (hcount, vcount, hs, vs, ad, nf, fc).
  - An internal started flag is cleared.
- First edge after reset release: outputs present position (0,0), fully decoded: ad_out = 1, hs = 0, vs = 0, nf = 0. The started flag is set.
- Each later edge advances the position:
  - h = h+1.
  - If h = H_TOTAL-1: h -> 0 and v = v+1.
  - If additionally v = V_TOTAL-1: v -> 0.
  - No skipped or repeated positions.
- Decodes, evaluated on the position being output:
  - ad = (h < ACTIVE_H_PIXELS) && (v < ACTIVE_LINES).
  - hs = 1 iff h in [ACTIVE_H_PIXELS+H_FRONT_PORCH, ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH), i.e. 1390..1429.
  - vs = 1 iff v in [ACTIVE_LINES+V_FRONT_PORCH, ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH), i.e. 725..729, for every h on those lines.
  - nf = 1 iff (h,v) = (ACTIVE_H_PIXELS, ACTIVE_LINES). This is exactly one cycle per frame: the first blanking position after the last active pixel.
- Frame counter:
  - fc increments on the same edge that nf asserts, so fc_out shows the new value in the nf cycle.
  - Wraps FPS-1 -> 0.
  - 0 after reset.
- Widths: counters are sized to the fixed port widths. Parameter sets exceeding 2047 / 1023 / 63 are unsupported.
- Reset mid-frame: takes effect on the next edge regardless of position. Release restarts at (0,0) with fc = 0; no partial-line state survives.

Decomposition:
- Package video_timing_pkg:
  - the nine timing constants;
  - derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END;
  - counter width localparams.
  - Shared with the scaler and the frame-buffer logic.
- One natural sub-module: wrap_counter (parameter MAX; inputs clk, rst, en; output count; terminal-count flag). Instantiate three times: h (en = 1), v (en = h terminal), fc (en = nf).

Test Plan:
1. Reset and release: hold rst_in high 3 cycles -> all outputs 0. First edge after release -> hcount 0, vcount 0, ad 1, hs 0, vs 0, nf 0, fc 0.
2. Line 0 horizontal sweep:
   - ad 1 through h = 1279, 0 at h = 1280.
   - hs rises at h = 1390, falls at h = 1430.
   - h = 1649 is followed by (0,1).
3. Vertical timing:
   - vs high for v = 725..729 at all h; low at v = 730.
   - ad 0 for v >= 720.
   - Position (1649,749) is followed by (0,0).
4. Frame pulse and counter:
   - nf high exactly once per frame, at (1280,720), and fc 0 -> 1 on that edge.
   - With reduced params (16/2/3/4 horizontal, 8/1/2/1 vertical, FPS = 4): after 4 frames fc wraps 3 -> 0. Sync windows scale accordingly (hs at h = 18..20).
5. Reset mid-frame: assert rst_in at (500,300), fc = 7 -> next edge all outputs 0. Release -> (0,0), fc 0, normal sweep resumes.
6. Scoreboard continuity: over 2 full frames, an independent (h,v) model matches every cycle, with no gaps or repeats. Count of ad-high cycles per frame = 921600.
